// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, widths and mode constants for the hazard controller
package hazard_pkg;

  localparam int RD_MAX_W    = 8;
  localparam int FWD_NONE    = 0;
  localparam int FWD_LOADUSE = 1;

  // rd is sized for the widest supported register file; narrower addresses are zero-extended
  typedef struct packed {
    logic                vld;
    logic [RD_MAX_W-1:0] rd;
    logic                wr;
    logic                ld;
  } sb_entry_t;

  function automatic int sq_cnt_w(input int br_squash);
    int w;
    w = $clog2(br_squash + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// rtl/hz_scoreboard.sv - in-flight write shift register and per-entry RAW match vector
module hz_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 3,
  parameter int NUM_STG = 2,
  parameter int ZERO_HW = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift_en,
  input  logic               push,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic               id_rs_used,
  input  logic               id_rt_used,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_regwrt,
  input  logic               id_is_load,
  output logic [NUM_STG-1:0] haz_vec,
  output logic               ent0_ld
);

  sb_entry_t [NUM_STG-1:0] sb_q, sb_d;
  sb_entry_t               new_ent;
  logic                    rs_chk, rt_chk;

  always_comb begin
    new_ent = '0;
    if (push) begin
      new_ent.vld = 1'b1;
      new_ent.rd  = RD_MAX_W'(id_rd);
      new_ent.wr  = id_regwrt;
      new_ent.ld  = id_is_load;
    end
    sb_d = sb_q;
    if (shift_en) begin
      sb_d[0] = new_ent;
      for (int k = 1; k < NUM_STG; k++) begin
        sb_d[k] = sb_q[k-1];
      end
    end
  end

  // a hardwired zero register can never carry a true dependency
  always_comb begin
    rs_chk = id_rs_used && !((ZERO_HW != 0) && (id_rs == '0));
    rt_chk = id_rt_used && !((ZERO_HW != 0) && (id_rt == '0));
    for (int k = 0; k < NUM_STG; k++) begin
      haz_vec[k] = sb_q[k].vld && sb_q[k].wr &&
                   ((rs_chk && (sb_q[k].rd == RD_MAX_W'(id_rs))) ||
                    (rt_chk && (sb_q[k].rd == RD_MAX_W'(id_rt))));
    end
    ent0_ld = sb_q[0].ld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/bubble/squash priority logic with squash and stall counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 3,
  parameter int NUM_STG   = 2,
  parameter int FWD_EN    = 0,
  parameter int BR_SQUASH = 1,
  parameter int ZERO_HW   = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrt,
  input  logic              id_is_load,
  input  logic              id_xfer,
  input  logic              freeze,
  input  logic              cnt_clr,
  output logic              stall,
  output logic              bubble,
  output logic              flush_if,
  output logic              issue,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int              SQ_W    = sq_cnt_w(BR_SQUASH);
  localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(BR_SQUASH);

  logic [NUM_STG-1:0] haz_vec;
  logic               ent0_ld;
  logic               squashing, data_haz;
  logic [SQ_W-1:0]    sq_cnt_q, sq_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  hz_scoreboard #(
    .REG_AW  (REG_AW),
    .NUM_STG (NUM_STG),
    .ZERO_HW (ZERO_HW)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en   (!freeze),
    .push       (issue),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .id_rd      (id_rd),
    .id_regwrt  (id_regwrt),
    .id_is_load (id_is_load),
    .haz_vec    (haz_vec),
    .ent0_ld    (ent0_ld)
  );

  always_comb begin
    squashing = (sq_cnt_q != '0);
    data_haz  = 1'b0;
    if (id_valid && !squashing) begin
      if (FWD_EN == FWD_LOADUSE) data_haz = haz_vec[0] && ent0_ld;
      else                       data_haz = |haz_vec;
    end
    stall    = data_haz || freeze;
    bubble   = (data_haz || squashing) && !freeze;
    issue    = id_valid && !data_haz && !squashing && !freeze;
    flush_if = squashing && !freeze;
  end

  // freeze holds every counter; a transfer only arms the window once it actually issues
  always_comb begin
    sq_cnt_d    = sq_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!freeze) begin
      if (issue && id_xfer) sq_cnt_d = SQ_LOAD;
      else if (squashing)   sq_cnt_d = sq_cnt_q - SQ_W'(1);
      if (cnt_clr)                                  stall_cnt_d = '0;
      else if (data_haz && (stall_cnt_q != '1))     stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      sq_cnt_q    <= sq_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench over three hazard_ctrl configurations
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs_used, id_rt_used, id_regwrt, id_is_load, id_xfer;
  logic [2:0] id_rs, id_rt, id_rd;
  logic       freeze, cnt_clr;

  logic        stall_w[3], bubble_w[3], issue_w[3], flush_w[3];
  logic [15:0] cnt_w[3];
  logic [1:0]  cnt2;

  typedef struct {
    int          dut;
    string       tag;
    logic [19:0] exp;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // u0: no forwarding, two squash slots; u1: load-use forwarding, zero hardwired; u2: one slot, 2-bit counter
  hazard_ctrl #(.REG_AW(3), .NUM_STG(2), .FWD_EN(0), .BR_SQUASH(2), .ZERO_HW(0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_regwrt(id_regwrt),
    .id_is_load(id_is_load), .id_xfer(id_xfer), .freeze(freeze), .cnt_clr(cnt_clr),
    .stall(stall_w[0]), .bubble(bubble_w[0]), .flush_if(flush_w[0]), .issue(issue_w[0]),
    .stall_cnt(cnt_w[0]));

  hazard_ctrl #(.REG_AW(3), .NUM_STG(2), .FWD_EN(1), .BR_SQUASH(2), .ZERO_HW(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_regwrt(id_regwrt),
    .id_is_load(id_is_load), .id_xfer(id_xfer), .freeze(freeze), .cnt_clr(cnt_clr),
    .stall(stall_w[1]), .bubble(bubble_w[1]), .flush_if(flush_w[1]), .issue(issue_w[1]),
    .stall_cnt(cnt_w[1]));

  hazard_ctrl #(.REG_AW(3), .NUM_STG(2), .FWD_EN(0), .BR_SQUASH(1), .ZERO_HW(0), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_regwrt(id_regwrt),
    .id_is_load(id_is_load), .id_xfer(id_xfer), .freeze(freeze), .cnt_clr(cnt_clr),
    .stall(stall_w[2]), .bubble(bubble_w[2]), .flush_if(flush_w[2]), .issue(issue_w[2]),
    .stall_cnt(cnt2));

  assign cnt_w[2] = {14'b0, cnt2};

  task automatic expect_o(input int d, input string tag, input logic st, input logic bu,
                          input logic is, input logic fl, input logic [15:0] c);
    exp_t e;
    e.dut = d;
    e.tag = tag;
    e.exp = {st, bu, is, fl, c};
    q.push_back(e);
  endtask

  task automatic check_now();
    exp_t        e;
    logic [19:0] got;
    while (q.size() > 0) begin
      e   = q.pop_front();
      got = {stall_w[e.dut], bubble_w[e.dut], issue_w[e.dut], flush_w[e.dut], cnt_w[e.dut]};
      tests++;
      assert (got === e.exp) else begin
        fails++;
        $error("FAIL %s dut%0d: got {stall,bubble,issue,flush,cnt}=%h expected %h",
               e.tag, e.dut, got, e.exp);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] rs, input logic rsu, input logic [2:0] rt,
                       input logic rtu, input logic [2:0] rd, input logic wr, input logic ld,
                       input logic xf);
    id_valid   = v;
    id_rs      = rs;
    id_rs_used = rsu;
    id_rt      = rt;
    id_rt_used = rtu;
    id_rd      = rd;
    id_regwrt  = wr;
    id_is_load = ld;
    id_xfer    = xf;
  endtask

  task automatic step();
    #3;
    check_now();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    freeze  = 1'b0;
    cnt_clr = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    freeze  = 1'b0;
    cnt_clr = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) expect_o(d, "reset", 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;

    // plain RAW without forwarding stalls for NUM_STG cycles
    drive(1, 1, 1, 2, 0, 3, 1, 0, 0); expect_o(0, "a_prod", 0, 0, 1, 0, 0); step();
    drive(1, 3, 1, 2, 0, 4, 1, 0, 0); expect_o(0, "a_st1",  1, 1, 0, 0, 0); step();
    expect_o(0, "a_st2", 1, 1, 0, 0, 1); step();
    expect_o(0, "a_iss", 0, 0, 1, 0, 2); step();

    // load-use stalls one cycle under forwarding
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0); expect_o(1, "b_ld",     0, 0, 1, 0, 0); step();
    drive(1, 0, 0, 5, 1, 6, 1, 0, 0); expect_o(1, "b_lu",     1, 1, 0, 0, 0); step();
    expect_o(1, "b_lu_iss", 0, 0, 1, 0, 1); step();

    // ALU producer is fully forwarded
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); expect_o(1, "b_alu", 0, 0, 1, 0, 0); step();
    drive(1, 0, 0, 5, 1, 6, 1, 0, 0); expect_o(1, "b_fwd", 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_o(1, "b_cnt", 0, 0, 0, 0, 0); step();

    // r0 dependency: ignored only when hardwired
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
    expect_o(0, "c_p0", 0, 0, 1, 0, 0); expect_o(1, "c_p1", 0, 0, 1, 0, 0); step();
    drive(1, 0, 1, 0, 0, 1, 1, 0, 0);
    expect_o(1, "c_zhw", 0, 0, 1, 0, 0); expect_o(0, "c_r0", 1, 1, 0, 0, 0); step();

    // squash window masks a RAW consumer
    do_reset();
    drive(1, 0, 0, 0, 0, 2, 1, 0, 1);
    expect_o(0, "d_br", 0, 0, 1, 0, 0); expect_o(2, "d_br2", 0, 0, 1, 0, 0); step();
    drive(1, 2, 1, 0, 0, 7, 1, 0, 0);
    expect_o(0, "d_sq1", 0, 1, 0, 1, 0); expect_o(2, "d_sq1b", 0, 1, 0, 1, 0); step();
    expect_o(0, "d_sq2", 0, 1, 0, 1, 0); expect_o(2, "d_raw",  1, 1, 0, 0, 0); step();
    expect_o(0, "d_done", 0, 0, 1, 0, 0); expect_o(2, "d_done2", 0, 0, 1, 0, 1); step();

    // freeze in the middle of a RAW stall
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0); expect_o(0, "e_p",  0, 0, 1, 0, 0); step();
    drive(1, 3, 1, 0, 0, 4, 1, 0, 0); expect_o(0, "e_st", 1, 1, 0, 0, 0); step();
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_o(0, "e_frz", 1, 0, 0, 0, 1); step();
    end
    freeze = 1'b0;
    expect_o(0, "e_rel", 1, 1, 0, 0, 1); step();
    expect_o(0, "e_iss", 0, 0, 1, 0, 2); step();

    // 2-bit stall counter saturation and clear
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0); expect_o(2, "f_p", 0, 0, 1, 0, 0); step();
    drive(1, 1, 1, 0, 0, 1, 1, 0, 0);
    expect_o(2, "f1", 1, 1, 0, 0, 0); step();
    expect_o(2, "f2", 1, 1, 0, 0, 1); step();
    expect_o(2, "f3", 0, 0, 1, 0, 2); step();
    expect_o(2, "f4", 1, 1, 0, 0, 2); step();
    expect_o(2, "f5", 1, 1, 0, 0, 3); step();
    expect_o(2, "f6", 0, 0, 1, 0, 3); step();
    expect_o(2, "f7", 1, 1, 0, 0, 3); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cnt_clr = 1'b1;
    expect_o(2, "f_clr", 0, 0, 0, 0, 3); step();
    cnt_clr = 1'b0;
    expect_o(2, "f_zero", 0, 0, 0, 0, 0); step();

    // asynchronous reset during a squash window
    do_reset();
    drive(1, 0, 0, 0, 0, 2, 1, 0, 1); expect_o(0, "g_br", 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    expect_o(0, "g_sq", 0, 1, 0, 1, 0);
    check_now();
    rst_n = 1'b0;
    #1;
    expect_o(0, "g_async", 0, 0, 0, 0, 0); expect_o(2, "g_async2", 0, 0, 0, 0, 0);
    check_now();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 2, 1, 0, 0, 3, 1, 0, 0); expect_o(0, "g_clean", 0, 0, 1, 0, 0); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the MIPS-style core. It sits beside the decode stage and tracks in-flight register writes in its own scoreboard, so callers supply no pipelined destination/write-enable copies. From that state it produces stall, bubble and fetch-squash controls. It supports a no-forwarding mode (stall on any RAW) and a forwarding mode (stall on load-use only), a configurable post-branch squash window, a global freeze, and a saturating stall-cycle counter.

## Interface
Parameters:
- REG_AW, 3: register address width.
- NUM_STG, 2: in-flight write stages tracked (1..4).
- FWD_EN, 0: 0 = stall on any RAW match in stages 0..NUM_STG-1; 1 = stall only on load-use (entry 0 is a load).
- BR_SQUASH, 1: fetch slots squashed after a control transfer issues (0..7).
- ZERO_HW, 0: 1 = address 0 is hardwired and never hazards.
- CNT_W, 16: stall-counter width.

Ports:
- clk, in, 1: clock. All state updates on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- id_valid, in, 1: ID holds a real instruction.
- id_rs / id_rt, in, REG_AW: source register addresses.
- id_rs_used / id_rt_used, in, 1: the source is actually read.
- id_rd, in, REG_AW: destination register address.
- id_regwrt, in, 1: the ID instruction writes id_rd.
- id_is_load, in, 1: the ID instruction is a load.
- id_xfer, in, 1: the ID instruction is a branch or jump that redirects fetch.
- freeze, in, 1: external whole-pipeline hold (memory busy).
- cnt_clr, in, 1: synchronous clear of stall_cnt.
- stall, out, 1: hold PC and the IF/ID register.
- bubble, out, 1: insert a NOP into ID/EX.
- flush_if, out, 1: squash the instruction being fetched.
- issue, out, 1: the ID instruction advances this cycle.
- stall_cnt, out, CNT_W: count of data-hazard stall cycles, saturating.

## Operation
- Scoreboard: NUM_STG entries, each {vld, rd, wr, ld}. Entry 0 is the youngest.
- haz_k: entry k has vld & wr, and its rd equals a used source (rs or rt). If ZERO_HW=1, a match on address 0 is ignored.
- squashing = (sq_cnt != 0).
- data_haz:
  - Forced to 0 when !id_valid or squashing.
  - FWD_EN=0: OR of haz_k over all k.
  - FWD_EN=1: haz_0 & entry0.ld.
- Outputs:
  - stall = data_haz | freeze.
  - bubble = (data_haz | squashing) & !freeze.
  - issue = id_valid & !data_haz & !squashing & !freeze.
  - flush_if = squashing & !freeze.
- When freeze=1, all state holds, including the scoreboard, sq_cnt and stall_cnt.
- When freeze=0, the scoreboard shifts (entry k moves to k+1; the oldest entry is discarded):
  - If issue=1, entry 0 loads {1, id_rd, id_regwrt, id_is_load}.
  - Otherwise entry 0 loads an invalid bubble.
- Squash counter, when freeze=0:
  - If issue & id_xfer, load BR_SQUASH.
  - Else if squashing, decrement.
  - id_xfer on a stalled or squashed instruction is ignored until that instruction issues.
- stall_cnt:
  - cnt_clr=1 (with freeze=0): clear to 0, taking priority over increment.
  - Otherwise increment by 1 when data_haz & !freeze.
  - Saturates at all-ones; no wrap.

## Timing
- stall, bubble, issue and flush_if are combinational from ID inputs plus registered state, with zero-cycle latency, and are valid in the same cycle.
- Reset (async assert, sync-safe deassert):
  - Outputs: stall=0, bubble=0, flush_if=0, issue=0 (no id_valid), stall_cnt=0.
  - State: all scoreboard entries invalid, sq_cnt=0.
- RAW stall length, producer then consumer back-to-back:
  - FWD_EN=0: NUM_STG cycles.
  - FWD_EN=1 with a load producer: 1 cycle.
  - FWD_EN=1 with a non-load producer: 0 cycles.
- After an issuing id_xfer, flush_if is high for exactly BR_SQUASH non-frozen cycles, starting the next cycle.
- Simultaneous events:
  - freeze dominates everything.
  - squashing masks data hazards.
  - An id_xfer that issues in the same cycle sq_cnt reaches 1 is impossible, because issue=0 while squashing.
- Reset mid-squash or mid-stall: the scoreboard is cleared immediately, so the next instruction issues without a stall.

## Structure
- hazard_pkg holds:
  - the sb_entry_t struct {vld, rd, wr, ld};
  - the width function for sq_cnt ($clog2(BR_SQUASH+1), minimum 1);
  - the mode constants FWD_NONE=0 and FWD_LOADUSE=1.
- One sub-module, hz_scoreboard: the shift register plus the per-entry match vector.
- The top level holds the priority logic, the squash counter and the stall counter.

## Test plan
- FWD_EN=0, NUM_STG=2: issue "wr r3", then a reader of rs=r3 → stall=1 and bubble=1 for 2 cycles, issue=1 on the 3rd cycle; stall_cnt=2.
- FWD_EN=1: issue a load to r5, then a reader of rt=r5 → 1 stall cycle. With an ALU producer to r5 instead → 0 stall cycles.
- ZERO_HW=1: producer writes r0, consumer reads r0 → no stall. With ZERO_HW=0 → a stall occurs.
- BR_SQUASH=2: issue with id_xfer=1 → flush_if=1 and bubble=1 for 2 cycles. A RAW-matching instruction arriving in ID during that window → no stall, and stall_cnt does not increment.
- Assert freeze for 3 cycles in the middle of a RAW stall → scoreboard, sq_cnt and stall_cnt hold, bubble=0. After release, the stall resumes with its remaining length.
- CNT_W=2: force 5 hazard cycles → stall_cnt saturates at 3. Then cnt_clr → 0. Then assert rst_n=0 during a squash → all outputs and state return to reset values asynchronously.
